// File: rtl/bit_serial_pkg.sv
// Shared types, defaults and helpers for the bit-serial transmitter and its matching receiver.
package bit_serial_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} ser_state_t;

  localparam int WIDTH_DEF = 8;
  localparam int GAP_DEF   = 1;

  // Even parity over any vector up to 64 bits; narrower vectors are zero-extended by the caller.
  function automatic logic even_parity(input logic [63:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word-side handshake and bit-side strobe bundle of the serializer.
// master = producer/sink environment, slave = the serializer itself.
interface bit_serializer_if
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_hold;
  logic             ser_data;
  logic             ser_en;
  logic             ser_last;
  logic             busy;

  modport master (
    output in_data, in_valid, ser_hold,
    input  in_ready, ser_data, ser_en, ser_last, busy
  );

  modport slave (
    input  in_data, in_valid, ser_hold,
    output in_ready, ser_data, ser_en, ser_last, busy
  );

endinterface

// File: rtl/bit_serializer_ser_bit_counter.sv
// Loadable up-counter with enable and a terminal-count flag; used for both bit and gap counting.
module ser_bit_counter #(
  parameter int W        = 4,
  parameter int TERMINAL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count;

  // Load wins over enable so a new word or gap always starts from a known value.
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en)
      count <= count + 1'b1;
  end

  assign tc = (count == W'(TERMINAL));

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter: one word in over valid/ready, one bit per cycle out with a strobe.
// Optional feature: define PARITY_EN to append an even-parity bit after the data bits.
module bit_serializer
  import bit_serial_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = GAP_DEF
) (
  input logic             clk,
  input logic             reset,
  bit_serializer_if.slave bus
);

`ifdef PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW     = $clog2(WIDTH + 1);
  localparam int GW     = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int GAP_TC = (GAP_CYCLES < 1) ? 0 : GAP_CYCLES - 1;

  ser_state_t       state;
  logic [NBITS-1:0] sreg;
  logic [NBITS-1:0] load_word;
  logic             bit_tc;
  logic             gap_tc;
  logic             accept;
  logic             advance;
  logic             last_bit;

  assign accept   = (state == IDLE) && bus.in_valid;
  assign advance  = (state == SHIFT) && !bus.ser_hold;
  assign last_bit = advance && bit_tc;

  // The parity bit sits at the far end of the shift register so it leaves after the data.
`ifdef PARITY_EN
  assign load_word = MSB_FIRST ? {bus.in_data, even_parity(64'(bus.in_data))}
                               : {even_parity(64'(bus.in_data)), bus.in_data};
`else
  assign load_word = bus.in_data;
`endif

  ser_bit_counter #(
    .W        (CW),
    .TERMINAL (NBITS - 1)
  ) u_bit_count (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val ('0),
    .en       (advance && !bit_tc),
    .tc       (bit_tc)
  );

  ser_bit_counter #(
    .W        (GW),
    .TERMINAL (GAP_TC)
  ) u_gap_count (
    .clk      (clk),
    .reset    (reset),
    .load     (last_bit),
    .load_val ('0),
    .en       ((state == GAP) && !gap_tc),
    .tc       (gap_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sreg  <= load_word;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!bus.ser_hold) begin
            sreg <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
            if (bit_tc)
              state <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (gap_tc)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ser_data keeps showing the pending bit under hold; only ser_en and ser_last drop.
  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.ser_en   = advance;
  assign bus.ser_last = last_bit;
  assign bus.ser_data = (state == SHIFT) && (MSB_FIRST ? sreg[NBITS-1] : sreg[0]);

endmodule

// File: tb/tb_bit_serializer.sv
// Randomized self-checking bench: an MSB-first and an LSB-first serializer run side by side against a word-level model.
module tb_bit_serializer;

  localparam int WIDTH = 8;
  localparam int GAP   = 1;
`ifdef PARITY_EN
  localparam int NSTROBE = WIDTH + 1;
`else
  localparam int NSTROBE = WIDTH;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic hold_now;

  bit_serializer_if #(.WIDTH(WIDTH)) bus_m ();
  bit_serializer_if #(.WIDTH(WIDTH)) bus_l ();

  bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .GAP_CYCLES(GAP)) dut_m (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m)
  );

  bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .GAP_CYCLES(GAP)) dut_l (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Bit k of the transmitted word: data bits in the chosen order, then parity if present.
  function automatic logic modelBit(input bit msb, input logic [WIDTH-1:0] w, input int k);
    if (k >= WIDTH) return ^w;
    return msb ? w[WIDTH-1-k] : w[k];
  endfunction

  task automatic driveInputs(input logic [WIDTH-1:0] data, input logic valid, input logic hold);
    bus_m.in_data  = data;  bus_l.in_data  = data;
    bus_m.in_valid = valid; bus_l.in_valid = valid;
    bus_m.ser_hold = hold;  bus_l.ser_hold = hold;
    hold_now       = hold;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ready_m"}, 32'(bus_m.in_ready), 32'd1);
    checkOutput({tag, "_ready_l"}, 32'(bus_l.in_ready), 32'd1);
    checkOutput({tag, "_en_m"},    32'(bus_m.ser_en),   32'd0);
    checkOutput({tag, "_en_l"},    32'(bus_l.ser_en),   32'd0);
    checkOutput({tag, "_busy_m"},  32'(bus_m.busy),     32'd0);
    checkOutput({tag, "_data_m"},  32'(bus_m.ser_data), 32'd0);
    checkOutput({tag, "_last_l"},  32'(bus_l.ser_last), 32'd0);
  endtask

  // Sends one word; hold_at/abort_at select a 3-cycle stall or a mid-word reset at that bit index (-1 = none).
  task automatic applyStimulus(input logic [WIDTH-1:0] word, input int hold_pct, input int hold_at,
                               input int abort_at, output int cycles);
    int   waited = 0;
    int   strobes = 0;
    int   hold_left = 0;
    bit   hold_used = 0;
    logic h;
    cycles = 0;
    while (bus_m.in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("ready_before_word", 32'(bus_m.in_ready), 32'd1);
    driveInputs(word, 1'b1, 1'($urandom_range(0, 1)));
    @(posedge clk); #1;
    while (strobes < NSTROBE && cycles < 200) begin
      if (hold_at >= 0 && strobes == hold_at && !hold_used) begin
        hold_left = 3;
        hold_used = 1;
      end
      if (hold_left > 0) begin
        h = 1'b1;
        hold_left--;
      end else begin
        h = ($urandom_range(0, 99) < hold_pct);
      end
      driveInputs(WIDTH'($urandom), 1'($urandom_range(0, 1)), h);
      @(negedge clk);
      checkOutput("shift_busy",  32'(bus_m.busy),     32'd1);
      checkOutput("shift_ready", 32'(bus_l.in_ready), 32'd0);
      checkOutput("en_m",   32'(bus_m.ser_en),   32'(!hold_now));
      checkOutput("en_l",   32'(bus_l.ser_en),   32'(!hold_now));
      checkOutput("data_m", 32'(bus_m.ser_data), 32'(modelBit(1'b1, word, strobes)));
      checkOutput("data_l", 32'(bus_l.ser_data), 32'(modelBit(1'b0, word, strobes)));
      checkOutput("last_m", 32'(bus_m.ser_last), 32'(!hold_now && strobes == NSTROBE - 1));
      checkOutput("last_l", 32'(bus_l.ser_last), 32'(!hold_now && strobes == NSTROBE - 1));
      if (!hold_now) strobes++;
      cycles++;
      @(posedge clk); #1;
      if (abort_at >= 0 && strobes == abort_at) begin
        reset = 1'b1;
        driveInputs(WIDTH'($urandom), 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkIdle("abort");
        repeat (3) begin
          @(posedge clk); #1;
          @(negedge clk);
          checkOutput("abort_no_strobe_m", 32'(bus_m.ser_en), 32'd0);
          checkOutput("abort_no_strobe_l", 32'(bus_l.ser_en), 32'd0);
        end
        return;
      end
    end
    checkOutput("word_strobes", 32'(strobes), 32'(NSTROBE));
    for (int g = 0; g < GAP; g++) begin
      driveInputs(WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      checkOutput("gap_ready", 32'(bus_m.in_ready), 32'd0);
      checkOutput("gap_en",    32'(bus_l.ser_en),   32'd0);
      checkOutput("gap_data",  32'(bus_m.ser_data), 32'd0);
      checkOutput("gap_busy",  32'(bus_l.busy),     32'd1);
      @(posedge clk); #1;
    end
    driveInputs(WIDTH'($urandom), 1'b0, 1'($urandom_range(0, 1)));
    @(negedge clk);
    checkIdle("after_word");
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    driveInputs('0, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkIdle("in_reset");
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkIdle("post_reset");

    applyStimulus(8'h1E, 0, -1, -1, cyc);
    checkOutput("unstalled_len", 32'(cyc), 32'(NSTROBE));
    applyStimulus(8'hA5, 0, 4, -1, cyc);
    checkOutput("stalled_len", 32'(cyc), 32'(NSTROBE + 3));
    applyStimulus(8'h5A, 0, -1, 5, cyc);
    applyStimulus(8'h3C, 0, -1, -1, cyc);
    checkOutput("after_abort_len", 32'(cyc), 32'(NSTROBE));
    applyStimulus(8'h07, 0, -1, -1, cyc);
    applyStimulus(8'h00, 0, -1, -1, cyc);
    applyStimulus(8'hFF, 0, -1, -1, cyc);

    for (int n = 0; n < 30; n++)
      applyStimulus(WIDTH'($urandom), 30, -1, -1, cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
